// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = data1 - data2) with iterative align/normalize.
// Optional round-to-nearest-even datapath (27 bits, extra ROUND cycle) enabled by defining ROUND_NEAREST_EN.
module fp_subtractor_seq #(
  parameter int SHIFT_PER_CYCLE = 1,
  parameter int MAX_ALIGN       = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

`ifdef ROUND_NEAREST_EN
  localparam int GRS = 3;
`else
  localparam int GRS = 0;
`endif
  localparam int MW = 25 + GRS;  // carry + hidden + 23 fraction (+ guard/round/sticky)
  localparam int HB = 23 + GRS;
  localparam int CB = 24 + GRS;
  localparam logic [7:0]  SPC  = 8'(SHIFT_PER_CYCLE);
  localparam logic [7:0]  MAXA = 8'(MAX_ALIGN);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

`ifdef ROUND_NEAREST_EN
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_DONE} state_t;
`endif

  function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [22:0] f);
    return {s, e, f};
  endfunction

  state_t        state;
  logic          sign_a, sign_b;
  logic [7:0]    exp_r;
  logic [MW-1:0] mant_a, mant_b;
  logic [7:0]    cnt;

  // Operand unpack; subtraction is done as addition of the negated subtrahend.
  logic        s1, s2;
  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic [MW-1:0] m1, m2;
  logic        a_big;
  logic [7:0]  diff;

  assign s1 = data1[31];
  assign s2 = ~data2[31];
  assign e1 = data1[30:23];
  assign e2 = data2[30:23];
  assign f1 = data1[22:0];
  assign f2 = data2[22:0];
  assign m1 = {{(MW-24){1'b0}}, 1'b1, f1} << GRS;
  assign m2 = {{(MW-24){1'b0}}, 1'b1, f2} << GRS;
  assign a_big = (e1 >= e2);
  assign diff  = a_big ? (e1 - e2) : (e2 - e1);

  logic        spec_hit, spec_ov;
  logic [31:0] spec_res;
  logic        z1, z2, inf1, inf2, nan1, nan2;

  assign z1   = (e1 == 8'h00);
  assign z2   = (e2 == 8'h00);
  assign inf1 = (e1 == 8'hFF) && (f1 == 23'h0);
  assign inf2 = (e2 == 8'hFF) && (f2 == 23'h0);
  assign nan1 = (e1 == 8'hFF) && (f1 != 23'h0);
  assign nan2 = (e2 == 8'hFF) && (f2 != 23'h0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    spec_hit = 1'b1;
    spec_ov  = 1'b0;
    spec_res = 32'h0;
    if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2))) begin
      spec_res = QNAN;
      spec_ov  = 1'b1;
    end else if (inf1) begin
      spec_res = {s1, 8'hFF, 23'h0};
      spec_ov  = 1'b1;
    end else if (inf2) begin
      spec_res = {s2, 8'hFF, 23'h0};
      spec_ov  = 1'b1;
    end else if (z1 && z2) begin
      spec_res = 32'h0;
    end else if (z2) begin
      spec_res = data1;
    end else if (z1) begin
      spec_res = {s2, data2[30:0]};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Alignment step: the last step may be shorter than SHIFT_PER_CYCLE.
  logic [7:0]    astep;
  logic [MW-1:0] mant_b_sh;
  always_comb begin
    astep     = (cnt < SPC) ? cnt : SPC;
    mant_b_sh = mant_b >> astep;
`ifdef ROUND_NEAREST_EN
    mant_b_sh[0] = mant_b_sh[0] | (|(mant_b & ~({MW{1'b1}} << astep)));
`endif
  end

  logic [MW-1:0] sum;
  logic          sum_sign;
  always_comb begin
    if (sign_a == sign_b) begin
      sum      = mant_a + mant_b;
      sum_sign = sign_a;
    end else if (mant_a >= mant_b) begin
      sum      = mant_a - mant_b;
      sum_sign = sign_a;
    end else begin
      sum      = mant_b - mant_a;
      sum_sign = sign_b;
    end
  end

  // Left-normalize step: never shift past the hidden-bit position.
  logic [7:0]    lstep;
  logic [MW-1:0] mant_l, mant_r;
  always_comb begin
    lstep = SPC;
    for (int k = SHIFT_PER_CYCLE; k >= 1; k--) begin
      if (mant_a[HB-k]) lstep = 8'(k);
    end
    mant_l = mant_a << lstep;
    mant_r = mant_a >> 1;
`ifdef ROUND_NEAREST_EN
    mant_r[0] = mant_r[0] | mant_a[0];
`endif
  end

`ifdef ROUND_NEAREST_EN
  logic        rnd_up;
  logic [24:0] rnd;
  always_comb begin
    rnd_up = mant_a[GRS-1] & ((|mant_a[GRS-2:0]) | mant_a[GRS]);
    rnd    = {1'b0, mant_a[HB:GRS]} + {24'h0, rnd_up};
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'h0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      // NOTE: datapath registers are not reset; they are always loaded on capture before use.
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (spec_hit) begin
              result    <= spec_res;
              overflow  <= spec_ov;
              underflow <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              sign_a <= a_big ? s1 : s2;
              sign_b <= a_big ? s2 : s1;
              exp_r  <= a_big ? e1 : e2;
              mant_a <= a_big ? m1 : m2;
              mant_b <= a_big ? m2 : m1;
              cnt    <= diff;
              state  <= (diff == 8'h0) ? S_SUB : S_ALIGN;
            end
          end
        end

        S_ALIGN: begin
          if (cnt > MAXA) begin
`ifdef ROUND_NEAREST_EN
            mant_b <= MW'(1);
`else
            mant_b <= '0;
`endif
            cnt    <= 8'h0;
            state  <= S_SUB;
          end else begin
            mant_b <= mant_b_sh;
            cnt    <= cnt - astep;
            if (cnt == astep) state <= S_SUB;
          end
        end

        S_SUB: begin
          if (sum == '0) begin
            result    <= 32'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            mant_a <= sum;
            sign_a <= sum_sign;
            if (sum[CB] || !sum[HB]) begin
              state <= S_NORM;
            end else begin
`ifdef ROUND_NEAREST_EN
              state <= S_ROUND;
`else
              result    <= pack(sum_sign, exp_r, sum[HB-1:GRS]);
              overflow  <= 1'b0;
              underflow <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
`endif
            end
          end
        end

        S_NORM: begin
          if (mant_a[CB]) begin
            if (exp_r == 8'd254) begin
              result    <= {sign_a, 8'hFF, 23'h0};
              overflow  <= 1'b1;
              underflow <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              exp_r  <= exp_r + 8'd1;
              mant_a <= mant_r;
`ifdef ROUND_NEAREST_EN
              state  <= S_ROUND;
`else
              result    <= pack(sign_a, exp_r + 8'd1, mant_r[HB-1:GRS]);
              overflow  <= 1'b0;
              underflow <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
`endif
            end
          end else if (exp_r <= lstep) begin
            result    <= {sign_a, 31'h0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            exp_r  <= exp_r - lstep;
            mant_a <= mant_l;
            if (mant_l[HB]) begin
`ifdef ROUND_NEAREST_EN
              state <= S_ROUND;
`else
              result    <= pack(sign_a, exp_r - lstep, mant_l[HB-1:GRS]);
              overflow  <= 1'b0;
              underflow <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
`endif
            end
          end
        end

`ifdef ROUND_NEAREST_EN
        S_ROUND: begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
          if (rnd[24]) begin
            if (exp_r == 8'd254) begin
              result   <= {sign_a, 8'hFF, 23'h0};
              overflow <= 1'b1;
            end else begin
              result <= pack(sign_a, exp_r + 8'd1, rnd[23:1]);
            end
          end else begin
            result <= pack(sign_a, exp_r, rnd[22:0]);
          end
        end
`endif

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq in its default build (SHIFT_PER_CYCLE=1, MAX_ALIGN=26, truncation).
module tb_fp_subtractor_seq;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] data1 = 32'h0;
  logic [31:0] data2 = 32'h0;
  logic        in_ready, out_valid, overflow, underflow;
  logic [31:0] result;

  always #5 CLK = ~CLK;

  fp_subtractor_seq dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    int          lat;
    int          acc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   first_valid = 0;
  bit   seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Latency counts the capture cycle through the first DONE cycle.
  always @(negedge CLK) begin
    if (nRST && out_valid) begin
      if (!seen) begin
        seen        = 1'b1;
        first_valid = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.tag, "_result"}, result, mon_e.res);
          check({mon_e.tag, "_overflow"}, 32'(overflow), 32'(mon_e.ov));
          check({mon_e.tag, "_underflow"}, 32'(underflow), 32'(mon_e.uf));
          check({mon_e.tag, "_latency"}, 32'(first_valid - mon_e.acc + 2), 32'(mon_e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic launch(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic ov, input logic uf,
                        input int lat, input bit track);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    data1    = a;
    data2    = b;
    in_valid = 1'b1;
    if (track) sb.push_back('{res: r, ov: ov, uf: uf, lat: lat, acc: cyc + 1, tag: tag});
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic ov, input logic uf, input int lat);
    launch(tag, a, b, r, ov, uf, lat, 1'b1);
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit stale;

    repeat (2) @(negedge CLK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // tag, data1, data2, result, overflow, underflow, latency
    run("t1_3m1",      32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4);
    run("t2_equal",    32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 3);
    run("t3_carry",    32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 4);
    run("t4_lshift",   32'h3F800000, 32'h3FC00000, 32'hBF000000, 1'b0, 1'b0, 4);
    run("t5_ovf",      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 4);
    run("t5_infinf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 2);
    run("nan_a",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 2);
    run("nan_b",       32'h3F800000, 32'h7F800001, 32'h7FC00000, 1'b1, 1'b0, 2);
    run("inf_b",       32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 2);
    run("ninf_minf",   32'hFF800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 2);
    run("pinf_mninf",  32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0, 2);
    run("x_minus_den", 32'h40490FDB, 32'h00000005, 32'h40490FDB, 1'b0, 1'b0, 2);
    run("zero_minus_y",32'h00000000, 32'h40490FDB, 32'hC0490FDB, 1'b0, 1'b0, 2);
    run("nzero_zero",  32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2);
    run("den_den",     32'h00000001, 32'h00400000, 32'h00000000, 1'b0, 1'b0, 2);
    run("neg_result",  32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0, 4);
    run("eff_add",     32'h40400000, 32'hC0000000, 32'h40A00000, 1'b0, 1'b0, 4);
    run("truncate",    32'h40000000, 32'h3F800001, 32'h3F800000, 1'b0, 1'b0, 5);
    run("diff26",      32'h3F800000, 32'h32800000, 32'h3F800000, 1'b0, 1'b0, 29);
    run("diff27",      32'h3F800000, 32'h32000000, 32'h3F800000, 1'b0, 1'b0, 4);
    run("diff102",     32'h3F800000, 32'h0C800000, 32'h3F800000, 1'b0, 1'b0, 4);
    run("uflow_pos",   32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 4);
    run("uflow_neg",   32'h00800000, 32'h00800001, 32'h80000000, 1'b0, 1'b1, 4);
    run("min_normal",  32'h01000000, 32'h00800000, 32'h00800000, 1'b0, 1'b0, 5);

    // Backpressure: result and flags must hold while out_ready is low.
    out_ready = 1'b0;
    launch("bp", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_hold_result", result, 32'h40000000);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge CLK);
    #1 out_ready = 1'b1;
    drain("bp");

    // Reset while aligning: the operation is discarded.
    launch("abort", 32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, 1'b0, 28, 1'b0);
    repeat (5) @(negedge CLK);
    check("abort_busy", 32'(in_ready), 32'd0);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", result, 32'h0);
    stale = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) stale = 1'b1;
    end
    check("abort_no_stale", 32'(stale), 32'd0);

    run("after_reset", 32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
